elastic_operator: RTL and testbench
===================================

ELASTIC_OPERATOR -- requirements
Module: elastic_operator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of every data word.
REQ-002 SHALL have parameter OP, default "reg", one of reg/in/out/addi/subi/muli/add/sub/mul.
REQ-003 SHALL have parameter IMMEDIATE, default 0, constant operand for addi/subi/muli.
REQ-004 SHALL have parameter INPUT_SIZE, default 1, operand channel count, legal 1..3.
REQ-005 SHALL have parameter OUTPUT_SIZE, default 1, consumer channel count, legal 1..8.
REQ-006 SHALL have parameter DEPTH, default 4, result FIFO entries, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-009 SHALL have port req_l, output, INPUT_SIZE, per-operand request to producer.
REQ-010 SHALL have port ack_l, input, INPUT_SIZE, per-operand acknowledge; din slice valid while high.
REQ-011 SHALL have port din, input, DATA_WIDTH*INPUT_SIZE, operand i in bits [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i].
REQ-012 SHALL have port req_r, input, OUTPUT_SIZE, per-consumer request.
REQ-013 SHALL have port ack_r, output, OUTPUT_SIZE, per-consumer one-cycle acknowledge.
REQ-014 SHALL have port dout, output, DATA_WIDTH, FIFO head result.
REQ-015 SHALL have port level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-016 SHALL have port op_count, output, 32, number of results pushed since reset.

Function
REQ-017 SHALL per operand i: assert req_l[i] next edge when has[i]=0 and req_l[i]=0.
REQ-018 SHALL on edge with ack_l[i]=1: capture din slice i into operand register, set has[i], clear req_l[i]; capture synchronous to clk, never on ack_l edges.
REQ-019 SHALL keep req_l[i] low while has[i]=1, so each operand slot holds at most one word.
REQ-020 SHALL push when all has bits are 1 and level<DEPTH at that edge; push clears all has bits in the same edge.
REQ-021 SHALL compute pushed value combinationally from operand registers: reg/in/out pass operand 0; addi/subi/muli use IMMEDIATE; add/sub/mul fold operands 0..INPUT_SIZE-1 left to right (op0 op op1 op op2); result truncated modulo 2^DATA_WIDTH.
REQ-022 SHALL, when level=DEPTH, hold has bits and operands unchanged (backpressure, no drop, no overwrite).
REQ-023 SHALL track taken[j] per consumer for the head entry.
REQ-024 SHALL register ack_r[j] = req_r[j] & head_valid & ~taken[j] & ~ack_r[j]; setting ack_r[j] sets taken[j].
REQ-025 SHALL hold dout equal to head entry while any ack_r bit is high; dout is don't-care when level=0.
REQ-026 SHALL pop the head on the edge where all taken bits are 1, clearing all taken bits in the same edge.
REQ-027 SHALL let consumers take the head independently; a slow consumer stalls only the pop, not other consumers' single acks.
REQ-028 SHALL on a same-edge push and pop keep level unchanged; push eligibility uses level before the edge (no same-cycle look-ahead when full).
REQ-029 SHALL latency: ack_l sampled at edge e0 -> push at e1 -> ack_r high after e2 (if req_r high) -> pop at e3.
REQ-030 SHALL wrap read/write pointers modulo DEPTH.
REQ-031 SHALL increment op_count by 1 per push, wrapping at 2^32.

Reset
REQ-032 SHALL on rst=1: req_l=0, ack_r=0, has=0, taken=0, pointers=0, level=0, op_count=0; FIFO contents unspecified.
REQ-033 SHALL on reset mid-transfer discard held operands and queued results; first req_l rises on the first edge after rst deasserts.

Configuration
REQ-034 SHALL with macro ELASTIC_OPERATOR_STATS_EN defined implement op_count per REQ-031; when undefined, drive op_count constant 0 and implement no counter logic.

Verification
REQ-035 SHALL cover: OP=add, INPUT_SIZE=2, operands 5 and 7 -> dout=12, ack_r pulses once, level returns 0.
REQ-036 SHALL cover: OP=addi, IMMEDIATE=2, DEPTH=4, req_r held 0, 6 inputs -> level=4, has=1, req_l=0; release req_r -> 6 results 2..7 in order, none lost.
REQ-037 SHALL cover: OUTPUT_SIZE=2, consumer 1 req delayed 10 cycles -> consumer 0 gets exactly one ack per entry, pop only after consumer 1 ack.
REQ-038 SHALL cover: OP=mul, DATA_WIDTH=8, operands 16 and 17 -> dout=0x10 (272 mod 256).
REQ-039 SHALL cover: rst asserted with level=3 -> next cycle level=0, ack_r=0, op_count=0; stream resumes correctly.
REQ-040 SHALL cover: STATS_EN defined vs undefined after 100 results -> op_count=100 vs 0.

Source files
------------

// File: rtl/elastic_operator.sv
// Elastic operator: request/acknowledge operand capture, combinational op, result FIFO
// fanned out to several consumers. Optional push counter behind ELASTIC_OPERATOR_STATS_EN.
module elastic_operator #(
   parameter int    DATA_WIDTH  = 32,
   parameter string OP          = "reg",
   parameter int    IMMEDIATE   = 0,
   parameter int    INPUT_SIZE  = 1,
   parameter int    OUTPUT_SIZE = 1,
   parameter int    DEPTH       = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [INPUT_SIZE-1:0]            req_l,
   input  logic [INPUT_SIZE-1:0]            ack_l,
   input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
   input  logic [OUTPUT_SIZE-1:0]           req_r,
   output logic [OUTPUT_SIZE-1:0]           ack_r,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic [$clog2(DEPTH):0]           level,
   output logic [31:0]                      op_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] IMM_W = DATA_WIDTH'(IMMEDIATE);

   logic [DATA_WIDTH-1:0]  opnd [INPUT_SIZE];
   logic [INPUT_SIZE-1:0]  has;
   logic [INPUT_SIZE-1:0]  cap;
   logic [DATA_WIDTH-1:0]  result;
   logic                   push;
   logic                   pop;
   logic                   head_valid;
   logic [OUTPUT_SIZE-1:0] taken;
   logic [OUTPUT_SIZE-1:0] ack_n;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;

   // A slot only accepts data while empty, so a held operand is never overwritten.
   assign cap        = ack_l & ~has;
   assign push       = (&has) && (level < FULL);
   assign head_valid = (level != '0);
   assign pop        = &taken;
   assign ack_n      = req_r & {OUTPUT_SIZE{head_valid}} & ~taken & ~ack_r;
   assign dout       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         req_l <= '0;
         has   <= '0;
      end else begin
         req_l <= ~has & ~cap;
         has   <= push ? '0 : (has | cap);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
         if (cap[i]) opnd[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   generate
      if (OP == "addi") begin : g_addi
         assign result = opnd[0] + IMM_W;
      end else if (OP == "subi") begin : g_subi
         assign result = opnd[0] - IMM_W;
      end else if (OP == "muli") begin : g_muli
         assign result = opnd[0] * IMM_W;
      end else if (OP == "add") begin : g_add
         always_comb begin
            result = opnd[0];
            for (int i = 1; i < INPUT_SIZE; i++) result = result + opnd[i];
         end
      end else if (OP == "sub") begin : g_sub
         always_comb begin
            result = opnd[0];
            for (int i = 1; i < INPUT_SIZE; i++) result = result - opnd[i];
         end
      end else if (OP == "mul") begin : g_mul
         always_comb begin
            result = opnd[0];
            for (int i = 1; i < INPUT_SIZE; i++) result = result * opnd[i];
         end
      end else begin : g_pass
         assign result = opnd[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= result;
   end

   // The head pops one edge after the last consumer has taken it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ack_r  <= '0;
         taken  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         ack_r <= ack_n;
         taken <= pop ? '0 : (taken | ack_n);
      end
   end

`ifdef ELASTIC_OPERATOR_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)       op_count <= '0;
      else if (push) op_count <= op_count + 32'd1;
   end
`else
   assign op_count = '0;
`endif

endmodule

// File: tb/tb_elastic_operator.sv
// Scoreboard bench for elastic_operator: several parameterisations share clk/rst;
// expected results are queued when stimulus is driven and matched on each ack_r.
module tb_elastic_operator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // a_: add, 2 operands, 32 bit
   logic [1:0]  a_req_l, a_ack_l;
   logic [63:0] a_din;
   logic        a_req_r, a_ack_r;
   logic [31:0] a_dout, a_op_count;
   logic [2:0]  a_level;
   // s_: sub, 3 operands, 16 bit
   logic [2:0]  s_req_l, s_ack_l;
   logic [47:0] s_din;
   logic        s_req_r, s_ack_r;
   logic [15:0] s_dout;
   logic [31:0] s_op_count;
   logic [2:0]  s_level;
   // m_: mul, 2 operands, 8 bit
   logic [1:0]  m_req_l, m_ack_l;
   logic [15:0] m_din;
   logic        m_req_r, m_ack_r;
   logic [7:0]  m_dout;
   logic [31:0] m_op_count;
   logic [2:0]  m_level;
   // i_: addi +2, 1 operand, depth 4
   logic        i_req_l, i_ack_l;
   logic [31:0] i_din;
   logic        i_req_r, i_ack_r;
   logic [31:0] i_dout, i_op_count;
   logic [2:0]  i_level;
   // c_: reg, 2 consumers
   logic        c_req_l, c_ack_l;
   logic [31:0] c_din;
   logic [1:0]  c_req_r, c_ack_r;
   logic [31:0] c_dout, c_op_count;
   logic [2:0]  c_level;

   logic [31:0] a_exp[$], a_obs[$];
   logic [15:0] s_exp[$], s_obs[$];
   logic [7:0]  m_exp[$], m_obs[$];
   logic [31:0] i_src[$], i_exp[$], i_obs[$];
   logic [31:0] c_exp0[$], c_exp1[$], c_obs0[$], c_obs1[$];
   int a_acks = 0, c_acks0 = 0, c_acks1 = 0;

   elastic_operator #(.DATA_WIDTH(32), .OP("add"), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4)) a_dut (
      .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din), .req_r(a_req_r),
      .ack_r(a_ack_r), .dout(a_dout), .level(a_level), .op_count(a_op_count));

   elastic_operator #(.DATA_WIDTH(16), .OP("sub"), .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(4)) s_dut (
      .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din), .req_r(s_req_r),
      .ack_r(s_ack_r), .dout(s_dout), .level(s_level), .op_count(s_op_count));

   elastic_operator #(.DATA_WIDTH(8), .OP("mul"), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4)) m_dut (
      .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din), .req_r(m_req_r),
      .ack_r(m_ack_r), .dout(m_dout), .level(m_level), .op_count(m_op_count));

   elastic_operator #(.DATA_WIDTH(32), .OP("addi"), .IMMEDIATE(2), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(4)) i_dut (
      .clk(clk), .rst(rst), .req_l(i_req_l), .ack_l(i_ack_l), .din(i_din), .req_r(i_req_r),
      .ack_r(i_ack_r), .dout(i_dout), .level(i_level), .op_count(i_op_count));

   elastic_operator #(.DATA_WIDTH(32), .OP("reg"), .INPUT_SIZE(1), .OUTPUT_SIZE(2), .DEPTH(4)) c_dut (
      .clk(clk), .rst(rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din), .req_r(c_req_r),
      .ack_r(c_ack_r), .dout(c_dout), .level(c_level), .op_count(c_op_count));

   // Output monitor: records the head value on every ack pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (a_ack_r) begin a_obs.push_back(a_dout); a_acks++; end
         if (s_ack_r) s_obs.push_back(s_dout);
         if (m_ack_r) m_obs.push_back(m_dout);
         if (i_ack_r) i_obs.push_back(i_dout);
         if (c_ack_r[0]) begin c_obs0.push_back(c_dout); c_acks0++; end
         if (c_ack_r[1]) begin c_obs1.push_back(c_dout); c_acks1++; end
      end
   end

   // Producer for the addi instance: serves i_src whenever req_l is high.
   initial begin
      i_ack_l = 1'b0;
      i_din   = '0;
      forever begin
         @(negedge clk);
         if (i_req_l && i_src.size() > 0) begin
            i_din   = i_src[0];
            i_ack_l = 1'b1;
            @(posedge clk); #1;
            void'(i_src.pop_front());
            i_ack_l = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic send_a(input logic [31:0] x0, input logic [31:0] x1);
      int t = 0;
      @(negedge clk);
      while (a_req_l != 2'b11 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (a_req_l != 2'b11) begin errors++; $display("FAIL add_req_timeout got %b exp 11", a_req_l); return; end
      a_din = {x1, x0}; a_ack_l = 2'b11;
      a_exp.push_back(x0 + x1);
      @(posedge clk); #1;
      a_ack_l = 2'b00;
   endtask

   task automatic send_s(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
      int t = 0;
      @(negedge clk);
      while (s_req_l != 3'b111 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (s_req_l != 3'b111) begin errors++; $display("FAIL sub_req_timeout got %b exp 111", s_req_l); return; end
      s_din = {x2, x1, x0}; s_ack_l = 3'b111;
      s_exp.push_back(x0 - x1 - x2);
      @(posedge clk); #1;
      s_ack_l = 3'b000;
   endtask

   task automatic send_m(input logic [7:0] x0, input logic [7:0] x1);
      int t = 0;
      @(negedge clk);
      while (m_req_l != 2'b11 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (m_req_l != 2'b11) begin errors++; $display("FAIL mul_req_timeout got %b exp 11", m_req_l); return; end
      m_din = {x1, x0}; m_ack_l = 2'b11;
      m_exp.push_back(x0 * x1);
      @(posedge clk); #1;
      m_ack_l = 2'b00;
   endtask

   task automatic send_c(input logic [31:0] x);
      int t = 0;
      @(negedge clk);
      while (!c_req_l && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (!c_req_l) begin errors++; $display("FAIL cons_req_timeout got 0 exp 1"); return; end
      c_din = x; c_ack_l = 1'b1;
      c_exp0.push_back(x); c_exp1.push_back(x);
      @(posedge clk); #1;
      c_ack_l = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (i_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", i_level); end
      checks++; if (i_ack_r !== 1'b0) begin errors++; $display("FAIL rst_ack_r got %b exp 0", i_ack_r); end
      checks++; if (i_req_l !== 1'b0) begin errors++; $display("FAIL rst_req_l got %b exp 0", i_req_l); end
      checks++; if (i_op_count !== 32'd0) begin errors++; $display("FAIL rst_op_count got %0d exp 0", i_op_count); end
      checks++; if (c_ack_r !== 2'b00) begin errors++; $display("FAIL rst_c_ack_r got %b exp 00", c_ack_r); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (a_req_l !== 2'b11) begin errors++; $display("FAIL rst_first_req got %b exp 11", a_req_l); end
      checks++; if (s_req_l !== 3'b111) begin errors++; $display("FAIL rst_first_req3 got %b exp 111", s_req_l); end
   endtask

   task automatic test_add();
      logic [31:0] e, g;
      a_req_r = 1'b1;
      send_a(32'd5, 32'd7);
      @(posedge clk); #1;
      checks++; if (a_level !== 3'd1) begin errors++; $display("FAIL add_push_lat got %0d exp 1", a_level); end
      checks++; if (a_ack_r !== 1'b0) begin errors++; $display("FAIL add_early_ack got %b exp 0", a_ack_r); end
      @(posedge clk); #1;
      checks++; if (a_ack_r !== 1'b1) begin errors++; $display("FAIL add_ack_lat got %b exp 1", a_ack_r); end
      @(posedge clk); #1;
      checks++; if (a_ack_r !== 1'b0) begin errors++; $display("FAIL add_ack_pulse got %b exp 0", a_ack_r); end
      checks++; if (a_level !== 3'd0) begin errors++; $display("FAIL add_pop got %0d exp 0", a_level); end
      send_a(32'hFFFF_FFFF, 32'd3);
      for (int t = 0; t < 50 && a_obs.size() < a_exp.size(); t++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (a_obs.size() != a_exp.size()) begin errors++; $display("FAIL add_count got %0d exp %0d", a_obs.size(), a_exp.size()); end
      while (a_exp.size() > 0 && a_obs.size() > 0) begin
         e = a_exp.pop_front(); g = a_obs.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL add_data got %h exp %h", g, e); end
      end
      checks++; if (a_acks != 2) begin errors++; $display("FAIL add_ack_count got %0d exp 2", a_acks); end
      checks++; if (a_level !== 3'd0) begin errors++; $display("FAIL add_level_end got %0d exp 0", a_level); end
      a_exp.delete(); a_obs.delete();
   endtask

   task automatic test_sub();
      logic [15:0] e, g;
      s_req_r = 1'b1;
      send_s(16'd100, 16'd30, 16'd5);
      send_s(16'd3, 16'd5, 16'd1);
      for (int t = 0; t < 50 && s_obs.size() < s_exp.size(); t++) @(negedge clk);
      checks++;
      if (s_obs.size() != s_exp.size()) begin errors++; $display("FAIL sub_count got %0d exp %0d", s_obs.size(), s_exp.size()); end
      while (s_exp.size() > 0 && s_obs.size() > 0) begin
         e = s_exp.pop_front(); g = s_obs.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL sub_data got %h exp %h", g, e); end
      end
      s_exp.delete(); s_obs.delete();
   endtask

   task automatic test_mul();
      logic [7:0] e, g;
      m_req_r = 1'b1;
      send_m(8'd16, 8'd17);
      send_m(8'd3, 8'd5);
      for (int t = 0; t < 50 && m_obs.size() < m_exp.size(); t++) @(negedge clk);
      checks++;
      if (m_obs.size() != m_exp.size()) begin errors++; $display("FAIL mul_count got %0d exp %0d", m_obs.size(), m_exp.size()); end
      while (m_exp.size() > 0 && m_obs.size() > 0) begin
         e = m_exp.pop_front(); g = m_obs.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL mul_data got %h exp %h", g, e); end
      end
      m_exp.delete(); m_obs.delete();
   endtask

   task automatic test_two_consumers();
      logic [31:0] e, g;
      c_req_r = 2'b01;
      send_c(32'hA5A5_0001);
      send_c(32'h5A5A_0002);
      repeat (10) @(negedge clk);
      checks++; if (c_acks0 != 1) begin errors++; $display("FAIL cons0_single_ack got %0d exp 1", c_acks0); end
      checks++; if (c_acks1 != 0) begin errors++; $display("FAIL cons1_no_ack got %0d exp 0", c_acks1); end
      checks++; if (c_level !== 3'd2) begin errors++; $display("FAIL cons_stall_level got %0d exp 2", c_level); end
      c_req_r = 2'b11;
      for (int t = 0; t < 100 && c_obs1.size() < 2; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (c_obs0.size() != 2 || c_obs1.size() != 2) begin
         errors++; $display("FAIL cons_count got %0d/%0d exp 2/2", c_obs0.size(), c_obs1.size());
      end
      while (c_exp0.size() > 0 && c_obs0.size() > 0) begin
         e = c_exp0.pop_front(); g = c_obs0.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL cons0_data got %h exp %h", g, e); end
      end
      while (c_exp1.size() > 0 && c_obs1.size() > 0) begin
         e = c_exp1.pop_front(); g = c_obs1.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL cons1_data got %h exp %h", g, e); end
      end
      checks++; if (c_level !== 3'd0) begin errors++; $display("FAIL cons_level_end got %0d exp 0", c_level); end
   endtask

   task automatic test_backpressure();
      logic [31:0] e, g;
      i_req_r = 1'b0;
      for (int k = 0; k < 6; k++) begin i_src.push_back(32'(k)); i_exp.push_back(32'(k + 2)); end
      repeat (30) @(negedge clk);
      checks++; if (i_level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d exp 4", i_level); end
      checks++; if (i_dut.has !== 1'b1) begin errors++; $display("FAIL bp_has got %b exp 1", i_dut.has); end
      checks++; if (i_req_l !== 1'b0) begin errors++; $display("FAIL bp_req_l got %b exp 0", i_req_l); end
      checks++; if (i_src.size() != 1) begin errors++; $display("FAIL bp_pending got %0d exp 1", i_src.size()); end
      i_req_r = 1'b1;
      for (int t = 0; t < 200 && i_obs.size() < 6; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (i_obs.size() != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", i_obs.size()); end
      while (i_exp.size() > 0 && i_obs.size() > 0) begin
         e = i_exp.pop_front(); g = i_obs.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL bp_data got %0d exp %0d", g, e); end
      end
      checks++; if (i_level !== 3'd0) begin errors++; $display("FAIL bp_level_end got %0d exp 0", i_level); end
      i_exp.delete(); i_obs.delete();
   endtask

   task automatic test_reset_mid();
      logic [31:0] e, g;
      i_req_r = 1'b0;
      for (int k = 0; k < 3; k++) begin i_src.push_back(32'(100 + k)); i_exp.push_back(32'(102 + k)); end
      for (int t = 0; t < 100 && i_level != 3'd3; t++) @(negedge clk);
      checks++; if (i_level !== 3'd3) begin errors++; $display("FAIL rm_fill got %0d exp 3", i_level); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (i_level !== 3'd0) begin errors++; $display("FAIL rm_level got %0d exp 0", i_level); end
      checks++; if (i_ack_r !== 1'b0) begin errors++; $display("FAIL rm_ack_r got %b exp 0", i_ack_r); end
      checks++; if (i_op_count !== 32'd0) begin errors++; $display("FAIL rm_op_count got %0d exp 0", i_op_count); end
      @(negedge clk); rst = 1'b0;
      i_exp.delete(); i_obs.delete();
      i_req_r = 1'b1;
      i_src.push_back(32'd10); i_exp.push_back(32'd12);
      i_src.push_back(32'd11); i_exp.push_back(32'd13);
      for (int t = 0; t < 100 && i_obs.size() < 2; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (i_obs.size() != 2) begin errors++; $display("FAIL rm_count got %0d exp 2", i_obs.size()); end
      while (i_exp.size() > 0 && i_obs.size() > 0) begin
         e = i_exp.pop_front(); g = i_obs.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL rm_data got %0d exp %0d", g, e); end
      end
      i_exp.delete(); i_obs.delete();
   endtask

   task automatic test_stats();
      logic [31:0] e, g;
      logic [31:0] exp_count;
`ifdef ELASTIC_OPERATOR_STATS_EN
      exp_count = 32'd100;
`else
      exp_count = 32'd0;
`endif
      i_req_r = 1'b1;
      for (int k = 0; k < 98; k++) begin i_src.push_back(32'(k * 3)); i_exp.push_back(32'(k * 3 + 2)); end
      for (int t = 0; t < 2000 && i_obs.size() < 98; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (i_obs.size() != 98) begin errors++; $display("FAIL stats_count got %0d exp 98", i_obs.size()); end
      while (i_exp.size() > 0 && i_obs.size() > 0) begin
         e = i_exp.pop_front(); g = i_obs.pop_front();
         checks++; if (g !== e) begin errors++; $display("FAIL stats_data got %0d exp %0d", g, e); end
      end
      checks++; if (i_op_count !== exp_count) begin errors++; $display("FAIL op_count got %0d exp %0d", i_op_count, exp_count); end
   endtask

   initial begin
      a_ack_l = '0; a_din = '0; a_req_r = 1'b0;
      s_ack_l = '0; s_din = '0; s_req_r = 1'b0;
      m_ack_l = '0; m_din = '0; m_req_r = 1'b0;
      c_ack_l = 1'b0; c_din = '0; c_req_r = '0;
      i_req_r = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_two_consumers();
      test_backpressure();
      test_reset_mid();
      test_stats();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
